// File: rtl/arbitro_escrita_banco_pkg.sv
// Shared sizing and requester identifiers for the register-bank write arbiter.
// The top module and the scoreboard both import these constants.
package arbitro_escrita_banco_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/arbitro_escrita_banco_placar_registradores.sv
// Pending-write scoreboard: one bit per register, set by decode and cleared on grant.
// Lookups are combinational from the registered bits; a same-register set and clear leaves the bit set.
module placar_registradores
    import arbitro_escrita_banco_pkg::*;
#(
    parameter int ADDR_W_P = arbitro_escrita_banco_pkg::ADDR_W,
    parameter int NREG_P   = arbitro_escrita_banco_pkg::NREG
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                set_en,
    input  logic [ADDR_W_P-1:0] set_reg,
    input  logic                clr_en,
    input  logic [ADDR_W_P-1:0] clr_reg,
    input  logic [ADDR_W_P-1:0] consulta1,
    input  logic [ADDR_W_P-1:0] consulta2,
    output logic                pendente1,
    output logic                pendente2
);

    logic [NREG_P-1:0] pend;

    // The set is written after the clear so that a new producer overrides the retiring one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            if (clr_en) pend[clr_reg] <= 1'b0;
            if (set_en) pend[set_reg] <= 1'b1;
        end
    end

    assign pendente1 = pend[consulta1];
    assign pendente2 = pend[consulta2];

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter for the single register-bank write port (ALU vs load), 1-cycle registered write stage.
// Grants are combinational; a losing requester holds its request and wins the next contended cycle.
module arbitro_escrita_banco
    import arbitro_escrita_banco_pkg::*;
#(
    parameter int DATA_W_P = arbitro_escrita_banco_pkg::DATA_W,
    parameter int ADDR_W_P = arbitro_escrita_banco_pkg::ADDR_W,
    parameter int NREG_P   = arbitro_escrita_banco_pkg::NREG
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alu_req,
    input  logic [ADDR_W_P-1:0] alu_reg,
    input  logic [DATA_W_P-1:0] alu_dado,
    output logic                alu_gnt,
    input  logic                mem_req,
    input  logic [ADDR_W_P-1:0] mem_reg,
    input  logic [DATA_W_P-1:0] mem_dado,
    output logic                mem_gnt,
    input  logic                reserva_en,
    input  logic [ADDR_W_P-1:0] reserva_reg,
    input  logic [ADDR_W_P-1:0] fonte1,
    input  logic [ADDR_W_P-1:0] fonte2,
    output logic                hazard,
    output logic                RegWrite,
    output logic [ADDR_W_P-1:0] registrador_dest,
    output logic [DATA_W_P-1:0] dado_escrita
);

    logic                ultimo;
    logic                transfere;
    logic [ADDR_W_P-1:0] reg_vencedor;
    logic [DATA_W_P-1:0] dado_vencedor;
    logic                pend1;
    logic                pend2;

    // Under contention the requester that did not win last is served.
    assign alu_gnt = alu_req & (~mem_req | (ultimo == REQ_MEM));
    assign mem_gnt = mem_req & (~alu_req | (ultimo == REQ_ALU));

    assign transfere     = alu_gnt | mem_gnt;
    assign reg_vencedor  = alu_gnt ? alu_reg  : mem_reg;
    assign dado_vencedor = alu_gnt ? alu_dado : mem_dado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ultimo           <= REQ_MEM;
            RegWrite         <= 1'b0;
            registrador_dest <= '0;
            dado_escrita     <= '0;
        end else begin
            RegWrite <= transfere;
            if (transfere) begin
                ultimo           <= alu_gnt ? REQ_ALU : REQ_MEM;
                registrador_dest <= reg_vencedor;
                dado_escrita     <= dado_vencedor;
            end
        end
    end

    // Pending bit retires at grant time, one cycle before the bank actually sees the write.
    placar_registradores #(
        .ADDR_W_P (ADDR_W_P),
        .NREG_P   (NREG_P)
    ) u_placar (
        .clock     (clock),
        .reset     (reset),
        .set_en    (reserva_en),
        .set_reg   (reserva_reg),
        .clr_en    (transfere),
        .clr_reg   (reg_vencedor),
        .consulta1 (fonte1),
        .consulta2 (fonte2),
        .pendente1 (pend1),
        .pendente2 (pend2)
    );

    assign hazard = pend1 | pend2;

endmodule
